// File: rtl/conv_param_seq.sv
// Sequential 2-D convolution: one multiplier, one MAC per cycle, row-major output pixels.
// Optional macro CONV_RELU_EN clamps negative sums to zero before saturation.
module conv_param_seq #(
    parameter int IN_DIM = 5,
    parameter int K      = 3,
    parameter int STRIDE = 1,
    parameter int DW     = 8,
    parameter int WW     = 8,
    parameter int OW     = 16,
    localparam int OUT_DIM = (IN_DIM - K) / STRIDE + 1,
    localparam int N_OUT   = OUT_DIM * OUT_DIM,
    localparam int ACC_W   = DW + WW + $clog2(K * K),
    localparam int IW      = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [IN_DIM*IN_DIM*DW-1:0] in_map,
    input  logic [K*K*WW-1:0]         weights,
    output logic                      busy,
    output logic                      pix_valid,
    output logic [OW-1:0]             pix_data,
    output logic [IW-1:0]             pix_idx,
    output logic [N_OUT*OW-1:0]       out_map,
    output logic                      done,
    output logic                      map_valid
);

    localparam int CW  = $clog2(OUT_DIM + 1);
    localparam int KCW = $clog2(K + 1);
    localparam int AW  = $clog2(IN_DIM * IN_DIM + 1);
    localparam int TW  = $clog2(K * K + 1);
    localparam int SW  = ((ACC_W > OW) ? ACC_W : OW) + 1;
    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, STORE, DONE} state_t;

    state_t state, state_nxt;

    logic [IN_DIM*IN_DIM*DW-1:0] map_r;
    logic [K*K*WW-1:0]           w_r;
    logic signed [ACC_W-1:0]     acc;
    logic [CW-1:0]               row, col;
    logic [KCW-1:0]              kr, kc;
    logic [IW-1:0]               pix_cnt;

    logic [AW-1:0]               pix_addr;
    logic [TW-1:0]               tap;
    logic signed [DW-1:0]        pix;
    logic signed [WW-1:0]        wt;
    logic signed [DW+WW-1:0]     prod;
    logic signed [SW-1:0]        acc_x, clip_in;
    logic [OW-1:0]               sat;
    logic                        last_tap, last_pix;

    assign last_tap = (kr == KCW'(K - 1)) && (kc == KCW'(K - 1));
    assign last_pix = (pix_cnt == IW'(N_OUT - 1));
    assign busy     = (state != IDLE);

    // Window origin is (row*STRIDE, col*STRIDE); kr/kc walk the kernel row-major.
    assign pix_addr = (AW'(row) * AW'(STRIDE) + AW'(kr)) * AW'(IN_DIM)
                    + AW'(col) * AW'(STRIDE) + AW'(kc);
    assign tap      = TW'(kr) * TW'(K) + TW'(kc);
    assign pix      = map_r[pix_addr*DW +: DW];
    assign wt       = w_r[tap*WW +: WW];
    assign prod     = pix * wt;

    assign acc_x = SW'(acc);
`ifdef CONV_RELU_EN
    assign clip_in = acc_x[SW-1] ? '0 : acc_x;
`else
    assign clip_in = acc_x;
`endif
    assign sat = (clip_in > SAT_MAX) ? SAT_MAX[OW-1:0] :
                 (clip_in < SAT_MIN) ? SAT_MIN[OW-1:0] : clip_in[OW-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !abort) state_nxt = MAC;
            MAC:     if (abort) state_nxt = IDLE;
                     else if (last_tap) state_nxt = STORE;
            STORE:   if (abort) state_nxt = IDLE;
                     else if (last_pix) state_nxt = DONE;
                     else state_nxt = MAC;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs are registered, so each lags the state that produces it by one edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            map_r     <= '0;
            w_r       <= '0;
            acc       <= '0;
            row       <= '0;
            col       <= '0;
            kr        <= '0;
            kc        <= '0;
            pix_cnt   <= '0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_idx   <= '0;
            out_map   <= '0;
            done      <= 1'b0;
            map_valid <= 1'b0;
        end else begin
            pix_valid <= 1'b0;
            done      <= 1'b0;
            if (abort) map_valid <= 1'b0;
            case (state)
                IDLE: if (start && !abort) begin
                    map_r     <= in_map;
                    w_r       <= weights;
                    acc       <= '0;
                    row       <= '0;
                    col       <= '0;
                    kr        <= '0;
                    kc        <= '0;
                    pix_cnt   <= '0;
                    map_valid <= 1'b0;
                end
                MAC: if (!abort) begin
                    acc <= acc + ACC_W'(prod);
                    if (kc == KCW'(K - 1)) begin
                        kc <= '0;
                        kr <= (kr == KCW'(K - 1)) ? '0 : kr + KCW'(1);
                    end else begin
                        kc <= kc + KCW'(1);
                    end
                end
                STORE: if (!abort) begin
                    out_map[pix_cnt*OW +: OW] <= sat;
                    pix_data  <= sat;
                    pix_idx   <= pix_cnt;
                    pix_valid <= 1'b1;
                    acc       <= '0;
                    pix_cnt   <= pix_cnt + IW'(1);
                    if (col == CW'(OUT_DIM - 1)) begin
                        col <= '0;
                        row <= row + CW'(1);
                    end else begin
                        col <= col + CW'(1);
                    end
                end
                DONE: if (!abort) begin
                    done      <= 1'b1;
                    map_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_param_seq.sv
// Directed bench for conv_param_seq: a default 5x5/3x3 instance, a 6x6 saturation instance
// and a stride-2 instance, with vector table plus abort/reset/ignored-start sequences.
module tb_conv_param_seq;

`ifdef CONV_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // default instance: 5x5 map, 3x3 kernel, stride 1
    logic         start0, abort0, busy0, pv0, done0, mv0;
    logic [199:0] map0;
    logic [71:0]  w0;
    logic [15:0]  pd0;
    logic [3:0]   pi0;
    logic [143:0] om0;

    // 6x6 map, 3x3 kernel, stride 1 -> 16 outputs
    logic         start1, abort1, busy1, pv1, done1, mv1;
    logic [287:0] map1;
    logic [71:0]  w1;
    logic [15:0]  pd1;
    logic [3:0]   pi1;
    logic [255:0] om1;

    // 5x5 map, 3x3 kernel, stride 2 -> 4 outputs
    logic         start2, abort2, busy2, pv2, done2, mv2;
    logic [199:0] map2;
    logic [71:0]  w2;
    logic [15:0]  pd2;
    logic [1:0]   pi2;
    logic [63:0]  om2;

    conv_param_seq dut0 (
        .clk(clk), .reset_n(reset_n), .start(start0), .abort(abort0),
        .in_map(map0), .weights(w0), .busy(busy0), .pix_valid(pv0),
        .pix_data(pd0), .pix_idx(pi0), .out_map(om0), .done(done0), .map_valid(mv0)
    );

    conv_param_seq #(.IN_DIM(6), .K(3), .STRIDE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .abort(abort1),
        .in_map(map1), .weights(w1), .busy(busy1), .pix_valid(pv1),
        .pix_data(pd1), .pix_idx(pi1), .out_map(om1), .done(done1), .map_valid(mv1)
    );

    conv_param_seq #(.IN_DIM(5), .K(3), .STRIDE(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .abort(abort2),
        .in_map(map2), .weights(w2), .busy(busy2), .pix_valid(pv2),
        .pix_data(pd2), .pix_idx(pi2), .out_map(om2), .done(done2), .map_valid(mv2)
    );

    typedef struct {
        logic [199:0] map;
        logic [71:0]  w;
        int           exp [9];
    } vec_t;

    vec_t vt [5];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int rl(input int x);
        return (RELU && x < 0) ? 0 : x;
    endfunction

    function automatic logic [199:0] map_ramp();
        logic [199:0] m;
        m = '0;
        for (int i = 0; i < 25; i++) m[i*8 +: 8] = 8'(i);
        return m;
    endfunction

    function automatic logic [199:0] map_fill(input logic [7:0] v);
        logic [199:0] m;
        for (int i = 0; i < 25; i++) m[i*8 +: 8] = v;
        return m;
    endfunction

    function automatic logic [71:0] w_fill(input logic [7:0] v);
        logic [71:0] w;
        for (int i = 0; i < 9; i++) w[i*8 +: 8] = v;
        return w;
    endfunction

    task automatic run_vec(input int vi, input bit disturb);
        int done_t, npv, seen;
        @(negedge clk);
        map0 = vt[vi].map; w0 = vt[vi].w; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk($sformatf("v%0d_busy", vi), int'(busy0), 1);
        done_t = -1; npv = 0;
        for (int t = 1; t <= 200 && done_t < 0; t++) begin
            @(negedge clk);
            if (pv0) begin
                if (npv < 9) begin
                    chk($sformatf("v%0d_pix_idx%0d", vi, npv), int'(pi0), npv);
                    chk($sformatf("v%0d_pix_data%0d", vi, npv), int'($signed(pd0)), vt[vi].exp[npv]);
                end
                npv++;
            end
            if (done0) done_t = t;
            start0 = disturb && (t == 30 || t == 90);
            if (disturb && t == 5) begin map0 = ~map0; w0 = ~w0; end
        end
        start0 = 1'b0;
        chk($sformatf("v%0d_done_latency", vi), done_t, 91);
        chk($sformatf("v%0d_pix_count", vi), npv, 9);
        chk($sformatf("v%0d_map_valid", vi), int'(mv0), 1);
        for (int i = 0; i < 9; i++)
            chk($sformatf("v%0d_out_map%0d", vi, i), int'($signed(om0[i*16 +: 16])), vt[vi].exp[i]);
        if (disturb) begin
            seen = 0;
            repeat (30) begin
                @(negedge clk);
                if (busy0 || pv0) seen = 1;
            end
            chk("ignored_start_no_rerun", seen, 0);
            chk("map_valid_holds", int'(mv0), 1);
        end
    endtask

    initial begin
        int seen, done_t, npv;
        int e2 [4];
        start0 = 0; abort0 = 0; map0 = '0; w0 = '0;
        start1 = 0; abort1 = 0; map1 = '0; w1 = '0;
        start2 = 0; abort2 = 0; map2 = '0; w2 = '0;

        vt[0].map = map_ramp();      vt[0].w = w_fill(8'd1);
        vt[0].exp = '{54, 63, 72, 99, 108, 117, 144, 153, 162};
        vt[1].map = map_fill(8'hFF); vt[1].w = w_fill(8'd1);
        for (int i = 0; i < 9; i++) vt[1].exp[i] = rl(-9);
        vt[2].map = map_ramp();      vt[2].w = '0; vt[2].w[39:32] = 8'd1;
        vt[2].exp = '{6, 7, 8, 11, 12, 13, 16, 17, 18};
        vt[3].map = map_fill(8'd127); vt[3].w = w_fill(8'h80);
        for (int i = 0; i < 9; i++) vt[3].exp[i] = RELU ? 0 : -32768;
        vt[4].map = map_ramp();      vt[4].w = '0; vt[4].w[7:0] = 8'd2; vt[4].w[71:64] = 8'hFF;
        vt[4].exp = '{-12, -11, -10, -7, -6, -5, -2, -1, 0};
        for (int i = 0; i < 9; i++) vt[4].exp[i] = rl(vt[4].exp[i]);

        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_pix_valid", int'(pv0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_map_valid", int'(mv0), 0);
        chk("rst_pix_data", int'(pd0), 0);
        chk("rst_pix_idx", int'(pi0), 0);
        chk("rst_out_map_nonzero", int'(om0 != '0), 0);
        reset_n = 1'b1;

        for (int vi = 0; vi < 5; vi++) run_vec(vi, vi == 0);
        run_vec(0, 1'b0);

        // abort at cycle 25: two pixels of the new run written, rest keep the previous run
        @(negedge clk);
        map0 = vt[2].map; w0 = vt[2].w; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (25) @(negedge clk);
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        chk("abort_busy", int'(busy0), 0);
        chk("abort_map_valid", int'(mv0), 0);
        chk("abort_out_map0", int'($signed(om0[15:0])), 6);
        chk("abort_out_map1", int'($signed(om0[31:16])), 7);
        chk("abort_out_map2_kept", int'($signed(om0[47:32])), 72);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (pv0 || done0 || busy0) seen = 1;
        end
        chk("abort_quiet", seen, 0);
        run_vec(2, 1'b0);

        // start together with abort in IDLE: no run
        @(negedge clk);
        start0 = 1'b1; abort0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; abort0 = 1'b0;
        chk("start_abort_busy", int'(busy0), 0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy0 || pv0) seen = 1;
        end
        chk("start_abort_no_run", seen, 0);

        // reset at cycle 40 of a run
        @(negedge clk);
        map0 = vt[0].map; w0 = vt[0].w; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (40) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy0), 0);
        chk("midrst_map_valid", int'(mv0), 0);
        chk("midrst_pix_data", int'(pd0), 0);
        chk("midrst_pix_idx", int'(pi0), 0);
        chk("midrst_out_map_nonzero", int'(om0 != '0), 0);
        @(negedge clk);
        reset_n = 1'b1;
        run_vec(0, 1'b0);

        // 6x6, everything 127: 9*127*127 = 145161 saturates
        @(negedge clk);
        for (int i = 0; i < 36; i++) map1[i*8 +: 8] = 8'd127;
        for (int i = 0; i < 9; i++) w1[i*8 +: 8] = 8'd127;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        done_t = -1; npv = 0;
        for (int t = 1; t <= 400 && done_t < 0; t++) begin
            @(negedge clk);
            if (pv1) npv++;
            if (done1) done_t = t;
        end
        chk("sat_done_latency", done_t, 161);
        chk("sat_pix_count", npv, 16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("sat_out_map%0d", i), int'($signed(om1[i*16 +: 16])), 32767);

        // stride 2, centre tap only
        @(negedge clk);
        map2 = map_ramp(); w2 = '0; w2[39:32] = 8'd1; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        e2 = '{6, 8, 16, 18};
        done_t = -1; npv = 0;
        for (int t = 1; t <= 200 && done_t < 0; t++) begin
            @(negedge clk);
            if (pv2) begin
                if (npv < 4) chk($sformatf("s2_pix_data%0d", npv), int'($signed(pd2)), e2[npv]);
                npv++;
            end
            if (done2) done_t = t;
        end
        chk("s2_done_latency", done_t, 41);
        chk("s2_pix_count", npv, 4);
        chk("s2_map_valid", int'(mv2), 1);
        for (int i = 0; i < 4; i++)
            chk($sformatf("s2_out_map%0d", i), int'($signed(om2[i*16 +: 16])), e2[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
